// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester drives START/A/B; the subtractor returns the result and status.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             BOUT;
  logic             OVF;
  logic             ZERO;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, A, B,
    input  D, BOUT, OVF, ZERO, BUSY, DONE
  );

  modport slave (
    input  START, A, B,
    output D, BOUT, OVF, ZERO, BUSY, DONE
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B, LSB first, one bit per clock.
// A single full-subtract step and a borrow flop; result registers load on FIN entry.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                CLK,
  input logic                RST,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             msba_q, msba_d;
  logic             msbb_q, msbb_d;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic a_bit, b_bit, d_bit, br_nxt;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    a_bit   = areg_q[0];
    b_bit   = breg_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_nxt = {d_bit, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    msba_d  = msba_q;
    msbb_d  = msbb_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          areg_d  = bus.A;
          breg_d  = bus.B;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          msba_d  = bus.A[WIDTH-1];
          msbb_d  = bus.B[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = res_nxt;
        areg_d = areg_q >> 1;
        breg_d = breg_q >> 1;
        br_d   = br_nxt;
        cnt_d  = cnt_q + 1'b1;
        // Last bit: publish the finished result as FIN is entered.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
          dout_d  = res_nxt;
          bout_d  = br_nxt;
          ovf_d   = (msba_q != msbb_q) & (res_nxt[WIDTH-1] != msba_q);
          zero_d  = (res_nxt == '0);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      msba_q  <= 1'b0;
      msbb_q  <= 1'b0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      msba_q  <= msba_d;
      msbb_q  <= msbb_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.D    = dout_q;
  assign bus.BOUT = bout_q;
  assign bus.OVF  = ovf_q;
  assign bus.ZERO = zero_q;
  assign bus.BUSY = (state_q != IDLE);
  assign bus.DONE = (state_q == FIN);
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of the bit-serial subtractor at WIDTH=8.
// Result outputs are also checked for stability on every clock.
module tb_serial_subtractor;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic          rst_seen;
  logic          prev_valid = 1'b0;
  logic [W+2:0]  prev_out;
  logic [W+2:0]  cur_out;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    rst_seen = RST;
    #1;
    cur_out = {bus.D, bus.BOUT, bus.OVF, bus.ZERO};
    if (prev_valid)
      check("hold_outside_fin",
            {31'd0, (cur_out === prev_out) | bus.DONE | rst_seen}, 1);
    prev_out   = cur_out;
    prev_valid = 1'b1;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (bus.DONE !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, bus.DONE, 1);
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] ed,
                        input logic eb,
                        input logic eo,
                        input logic ez);
    int n;
    bus.A     = a;
    bus.B     = b;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.A     = ~a;
    bus.B     = a ^ 8'h5C;
    check({tag, "_busy"}, bus.BUSY, 1);
    wait_done(tag, n);
    check({tag, "_latency"}, n, W);
    check({tag, "_d"}, bus.D, ed);
    check({tag, "_bout"}, bus.BOUT, eb);
    check({tag, "_ovf"}, bus.OVF, eo);
    check({tag, "_zero"}, bus.ZERO, ez);
    check({tag, "_busy_fin"}, bus.BUSY, 1);
    tick();
    check({tag, "_done_1cyc"}, bus.DONE, 0);
    check({tag, "_idle"}, bus.BUSY, 0);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb, ed;
    logic [W:0]   diff;
    logic         eo;

    RST       = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    check("rst_d", bus.D, 0);
    check("rst_bout", bus.BOUT, 0);
    check("rst_ovf", bus.OVF, 0);
    check("rst_zero", bus.ZERO, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);

    // Reset wins over a simultaneous START.
    bus.START = 1'b1;
    bus.A     = 8'h11;
    tick();
    check("rst_prio_busy", bus.BUSY, 0);
    RST       = 1'b0;
    bus.START = 1'b0;
    tick();
    check("idle_busy", bus.BUSY, 0);

    run_op("t1", 8'h5A, 8'h13, 8'h47, 0, 0, 0);
    run_op("t2a", 8'h13, 8'h5A, 8'hB9, 1, 0, 0);
    run_op("t2b", 8'h80, 8'h01, 8'h7F, 0, 1, 0);
    run_op("t3a", 8'h3C, 8'h3C, 8'h00, 0, 0, 1);
    run_op("t3b", 8'h00, 8'hFF, 8'h01, 1, 0, 0);
    run_op("t3c", 8'h7F, 8'hFF, 8'h80, 1, 1, 0);

    // START during RUN is ignored.
    bus.A     = 8'h5A;
    bus.B     = 8'h13;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    bus.START = 1'b1;
    bus.A     = 8'h01;
    bus.B     = 8'h02;
    tick();
    bus.START = 1'b0;
    wait_done("t4a", n);
    check("t4a_latency", n, 5);
    check("t4a_d", bus.D, 8'h47);
    check("t4a_bout", bus.BOUT, 0);
    tick();
    check("t4a_idle", bus.BUSY, 0);

    // START held high: one operation every W+2 cycles.
    bus.A     = 8'h10;
    bus.B     = 8'h01;
    bus.START = 1'b1;
    tick();
    bus.A     = 8'h77;
    bus.B     = 8'h11;
    wait_done("t4b1", n);
    check("t4b1_latency", n, W);
    check("t4b1_d", bus.D, 8'h0F);
    tick();
    check("t4b_gap_idle", bus.BUSY, 0);
    tick();
    check("t4b2_busy", bus.BUSY, 1);
    bus.A     = 8'h00;
    bus.B     = 8'h01;
    wait_done("t4b2", n);
    check("t4b2_latency", n, W);
    check("t4b2_d", bus.D, 8'h66);
    check("t4b2_bout", bus.BOUT, 0);
    bus.START = 1'b0;
    tick();
    tick();
    check("t4b_end_idle", bus.BUSY, 0);

    // Abort by reset on the 4th RUN cycle.
    bus.A     = 8'h5A;
    bus.B     = 8'h13;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
    tick();
    tick();
    check("t5_run", bus.BUSY, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_busy", bus.BUSY, 0);
    check("t5_done", bus.DONE, 0);
    check("t5_d", bus.D, 0);
    check("t5_bout", bus.BOUT, 0);
    check("t5_ovf", bus.OVF, 0);
    check("t5_zero", bus.ZERO, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n += int'(bus.DONE);
    end
    check("t5_no_done", n, 0);
    run_op("t5b", 8'hFF, 8'h01, 8'hFE, 0, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom_range(0, 255));
      rb   = W'($urandom_range(0, 255));
      diff = {1'b0, ra} - {1'b0, rb};
      ed   = diff[W-1:0];
      eo   = (ra[W-1] != rb[W-1]) && (ed[W-1] != ra[W-1]);
      run_op("rnd", ra, rb, ed, diff[W], eo, ed == '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
